// File: rtl/sbox_lane_arbiter_if.sv
// Signal bundle linking the round datapath, the key expander and the shared
// 32-bit S-box lane to the lane arbiter.
interface sbox_lane_arbiter_if;
  logic         stateReq;
  logic [127:0] stateIn;
  logic         stateDone;
  logic [127:0] stateOut;
  logic         keyReq;
  logic [31:0]  keyWord;
  logic         keyRot;
  logic         keyDone;
  logic [31:0]  keyOut;
  logic [31:0]  sboxIn;
  logic [31:0]  sboxOut;
  logic         busy;

  modport slave (
    input  stateReq, stateIn, keyReq, keyWord, keyRot, sboxOut,
    output stateDone, stateOut, keyDone, keyOut, sboxIn, busy
  );

  modport master (
    output stateReq, stateIn, keyReq, keyWord, keyRot, sboxOut,
    input  stateDone, stateOut, keyDone, keyOut, sboxIn, busy
  );
endinterface

// File: rtl/sbox_lane_arbiter.sv
// Time-multiplexes one 4-byte S-box lane between a 128-bit SubBytes requester
// (four column passes) and a 32-bit SubWord/RotWord requester (one pass).
module sbox_lane_arbiter #(
  parameter int unsigned KEY_PRIORITY = 0
) (
  input logic               clk,
  input logic               rst,
  sbox_lane_arbiter_if.slave bus
);

  typedef enum logic [2:0] {IDLE, S_RUN, S_DONE, K_RUN, K_DONE} fsmState;
  typedef enum logic {GRANT_STATE, GRANT_KEY} grantOwner;

  fsmState         fsm;
  grantOwner       lastGrant;
  logic [1:0]      colCnt;
  logic [1:0]      nextCol;
  logic [0:3][31:0] stateBuf;
  logic [31:0]     keyWordRot;
  logic            grantKey;
  logic            grantState;

  // A tie goes to the key side under fixed priority, otherwise to whoever lost last time.
  assign grantKey   = bus.keyReq &&
                      (!bus.stateReq || (KEY_PRIORITY != 0) || (lastGrant == GRANT_STATE));
  assign grantState = bus.stateReq && !grantKey;
  assign nextCol    = colCnt + 2'd1;
  assign keyWordRot = bus.keyRot ? {bus.keyWord[23:0], bus.keyWord[31:24]} : bus.keyWord;

  // NOTE: the column buffer is pure datapath, always loaded at grant before it is
  // read, so it carries no reset and stays out of the control block.
  always_ff @(posedge clk) begin
    if (fsm == IDLE && grantState) begin
      stateBuf <= bus.stateIn;
    end else if (fsm == S_RUN) begin
      stateBuf[colCnt] <= bus.sboxOut;
    end
  end

  // NOTE: every output is a flop driven from this block, so sboxIn is loaded one
  // edge ahead with the column the lane must see during the next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm           <= IDLE;
      lastGrant     <= GRANT_KEY;
      colCnt        <= 2'd0;
      bus.stateOut  <= '0;
      bus.keyOut    <= '0;
      bus.stateDone <= 1'b0;
      bus.keyDone   <= 1'b0;
      bus.sboxIn    <= '0;
      bus.busy      <= 1'b0;
    end else begin
      bus.stateDone <= 1'b0;
      bus.keyDone   <= 1'b0;
      unique case (fsm)
        IDLE: begin
          if (grantKey) begin
            bus.sboxIn <= keyWordRot;
            lastGrant  <= GRANT_KEY;
            bus.busy   <= 1'b1;
            fsm        <= K_RUN;
          end else if (grantState) begin
            bus.sboxIn <= bus.stateIn[127:96];
            colCnt     <= 2'd0;
            lastGrant  <= GRANT_STATE;
            bus.busy   <= 1'b1;
            fsm        <= S_RUN;
          end
        end
        S_RUN: begin
          if (colCnt == 2'd3) begin
            bus.stateOut  <= {stateBuf[0], stateBuf[1], stateBuf[2], bus.sboxOut};
            bus.stateDone <= 1'b1;
            bus.sboxIn    <= '0;
            fsm           <= S_DONE;
          end else begin
            bus.sboxIn <= stateBuf[nextCol];
            colCnt     <= nextCol;
          end
        end
        S_DONE: begin
          colCnt   <= 2'd0;
          bus.busy <= 1'b0;
          fsm      <= IDLE;
        end
        K_RUN: begin
          bus.keyOut  <= bus.sboxOut;
          bus.keyDone <= 1'b1;
          bus.sboxIn  <= '0;
          fsm         <= K_DONE;
        end
        K_DONE: begin
          bus.busy <= 1'b0;
          fsm      <= IDLE;
        end
        default: begin
          bus.sboxIn <= '0;
          bus.busy   <= 1'b0;
          fsm        <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sbox_lane_arbiter.sv
// Directed bench for the S-box lane arbiter: one instance per tie-break policy,
// each fed by an AES S-box lane model built from GF(2^8) inversion.
module tb_sbox_lane_arbiter;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  logic [7:0] sbox [256];

  always #5 clk = ~clk;

  sbox_lane_arbiter_if bus0();
  sbox_lane_arbiter_if bus1();

  sbox_lane_arbiter #(.KEY_PRIORITY(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));
  sbox_lane_arbiter #(.KEY_PRIORITY(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] sboxCalc(input logic [7:0] a);
    logic [7:0] inv = 8'h00;
    for (int i = 1; i < 256; i++) begin
      if (gmul(a, 8'(i)) == 8'h01) inv = 8'(i);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  always_comb begin
    bus0.sboxOut = {sbox[bus0.sboxIn[31:24]], sbox[bus0.sboxIn[23:16]],
                    sbox[bus0.sboxIn[15:8]],  sbox[bus0.sboxIn[7:0]]};
    bus1.sboxOut = {sbox[bus1.sboxIn[31:24]], sbox[bus1.sboxIn[23:16]],
                    sbox[bus1.sboxIn[15:8]],  sbox[bus1.sboxIn[7:0]]};
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  localparam logic [127:0] VEC_A  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] SUB_A  = 128'h638293c31bfc33f5c4eeacea4bc12816;
  localparam logic [127:0] VEC_B  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] SUB_B  = 128'h637c777bf26b6fc53001672bfed7ab76;
  localparam logic [31:0]  KWORD  = 32'h09cf4f3c;

  int         nDone;
  int         nKey;
  int         dbl;
  int         waited;
  logic [3:0] order;
  logic       prevS;
  logic       prevK;
  logic       earlyState;

  initial begin
    for (int i = 0; i < 256; i++) sbox[i] = sboxCalc(8'(i));

    rst = 1'b1;
    bus0.stateReq = 1'b0; bus0.stateIn = '0; bus0.keyReq = 1'b0; bus0.keyWord = '0; bus0.keyRot = 1'b0;
    bus1.stateReq = 1'b0; bus1.stateIn = '0; bus1.keyReq = 1'b0; bus1.keyWord = '0; bus1.keyRot = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_busy",     bus0.busy, 0);
    check("rst_stateOut", bus0.stateOut, 0);
    check("rst_keyOut",   bus0.keyOut, 0);
    check("rst_sboxIn",   bus0.sboxIn, 0);
    check("rst_dones",    {bus0.stateDone, bus0.keyDone}, 0);
    check("rst_busy_kp1", bus1.busy, 0);
    rst = 1'b0;

    // Single SubBytes: column walk, latency and result
    bus0.stateIn = VEC_A; bus0.stateReq = 1'b1;
    @(negedge clk); check("t1_col0", bus0.sboxIn, 32'h00112233); check("t1_busy", bus0.busy, 1);
    @(negedge clk); check("t1_col1", bus0.sboxIn, 32'h44556677);
    @(negedge clk); check("t1_col2", bus0.sboxIn, 32'h8899aabb);
    @(negedge clk); check("t1_col3", bus0.sboxIn, 32'hccddeeff); check("t1_nodone", bus0.stateDone, 0);
    @(negedge clk); check("t1_done", bus0.stateDone, 1); check("t1_out", bus0.stateOut, SUB_A);
    check("t1_sbox_idle", bus0.sboxIn, 0);
    bus0.stateReq = 1'b0;
    @(negedge clk); check("t1_done_pulse", bus0.stateDone, 0); check("t1_idle", bus0.busy, 0);

    // SubWord with and without RotWord
    bus0.keyWord = KWORD; bus0.keyRot = 1'b1; bus0.keyReq = 1'b1;
    @(negedge clk); check("t2_rot_sboxIn", bus0.sboxIn, 32'hcf4f3c09); check("t2_busy", bus0.busy, 1);
    @(negedge clk); check("t2_rot_done", bus0.keyDone, 1); check("t2_rot_out", bus0.keyOut, 32'h8a84eb01);
    bus0.keyReq = 1'b0;
    @(negedge clk); check("t2_done_pulse", bus0.keyDone, 0); check("t2_idle", bus0.busy, 0);
    bus0.keyRot = 1'b0; bus0.keyReq = 1'b1;
    @(negedge clk); check("t2_norot_sboxIn", bus0.sboxIn, KWORD);
    @(negedge clk); check("t2_norot_done", bus0.keyDone, 1); check("t2_norot_out", bus0.keyOut, 32'h018a84eb);
    bus0.keyReq = 1'b0;
    @(negedge clk);

    // Round-robin contention: state, key, state, key
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    bus0.stateIn = VEC_A; bus0.keyWord = KWORD; bus0.keyRot = 1'b0;
    bus0.stateReq = 1'b1; bus0.keyReq = 1'b1;
    nDone = 0; dbl = 0; order = '0; prevS = 1'b0; prevK = 1'b0;
    for (int c = 0; c < 60 && nDone < 4; c++) begin
      @(negedge clk);
      if (bus0.stateDone && bus0.keyDone) dbl++;
      if ((bus0.stateDone && prevS) || (bus0.keyDone && prevK)) dbl++;
      if (bus0.stateDone) begin
        if (nDone < 4) order[nDone] = 1'b0;
        nDone++;
        check("t3_state_out", bus0.stateOut, SUB_A);
      end
      if (bus0.keyDone) begin
        if (nDone < 4) order[nDone] = 1'b1;
        nDone++;
        check("t3_key_out", bus0.keyOut, 32'h018a84eb);
      end
      prevS = bus0.stateDone; prevK = bus0.keyDone;
    end
    bus0.stateReq = 1'b0; bus0.keyReq = 1'b0;
    check("t3_done_count", nDone, 4);
    check("t3_order", order, 4'b1010);
    check("t3_single_pulses", dbl, 0);
    repeat (2) @(negedge clk);
    check("t3_idle", bus0.busy, 0);

    // Fixed key priority: key wins every tie, state served once key drops
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    bus1.stateIn = VEC_B; bus1.keyWord = KWORD; bus1.keyRot = 1'b1;
    bus1.stateReq = 1'b1; bus1.keyReq = 1'b1;
    nKey = 0; earlyState = 1'b0;
    for (int c = 0; c < 30 && nKey < 3; c++) begin
      @(negedge clk);
      if (bus1.stateDone) earlyState = 1'b1;
      if (bus1.keyDone) nKey++;
    end
    bus1.keyReq = 1'b0;
    check("t4_key_count", nKey, 3);
    check("t4_state_starved", earlyState, 0);
    check("t4_key_out", bus1.keyOut, 32'h8a84eb01);
    waited = -1;
    for (int c = 1; c <= 20 && waited < 0; c++) begin
      @(negedge clk);
      if (bus1.stateDone) waited = c;
    end
    bus1.stateReq = 1'b0;
    check("t4_state_served", waited > 0, 1);
    check("t4_state_out", bus1.stateOut, SUB_B);
    @(negedge clk);

    // Input change after grant has no effect
    bus0.stateIn = VEC_B; bus0.stateReq = 1'b1;
    @(negedge clk); bus0.stateIn = VEC_A;
    waited = -1;
    for (int c = 1; c <= 10 && waited < 0; c++) begin
      @(negedge clk);
      if (bus0.stateDone) waited = c;
    end
    bus0.stateReq = 1'b0;
    check("t5_latency", waited, 4);
    check("t5_out", bus0.stateOut, SUB_B);
    @(negedge clk);

    // Reset during the third S_RUN cycle, then a fresh grant
    bus0.stateIn = VEC_A; bus0.stateReq = 1'b1;
    repeat (3) @(negedge clk);
    check("t6_third_col", bus0.sboxIn, 32'h8899aabb);
    rst = 1'b1;
    @(negedge clk);
    check("t6_busy", bus0.busy, 0);
    check("t6_stateOut", bus0.stateOut, 0);
    check("t6_nodone", bus0.stateDone, 0);
    check("t6_sboxIn", bus0.sboxIn, 0);
    rst = 1'b0;
    waited = -1;
    for (int c = 1; c <= 10 && waited < 0; c++) begin
      @(negedge clk);
      if (bus0.stateDone) waited = c;
    end
    bus0.stateReq = 1'b0;
    check("t6_latency", waited, 5);
    check("t6_out", bus0.stateOut, SUB_A);
    repeat (2) @(negedge clk);
    check("t6_idle", bus0.busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
